// File: rtl/decode_pkg.sv
// ============================================================================
// Module   : decode_pkg
// Brief    : Instruction field positions, opcode set and illegal-opcode base.
// Revision : 1.0
// ============================================================================
`default_nettype none

package decode_pkg;

    localparam int INSTR_W = 32;
    localparam int OPC_W   = 6;
    localparam int REG_W   = 4;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 22;
    localparam int RS_MSB  = 21;
    localparam int RS_LSB  = 18;
    localparam int IMM_MSB = 17;
    localparam int IMM_LSB = 0;

    // Opcodes from this value upward are reserved.
    localparam logic [OPC_W-1:0] ILLEGAL_BASE = 6'h30;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP   = 6'h00,
        OP_ADD   = 6'h01,
        OP_SUB   = 6'h02,
        OP_AND   = 6'h03,
        OP_OR    = 6'h04,
        OP_ADDI  = 6'h05,
        OP_LD    = 6'h10,
        OP_ST    = 6'h11,
        OP_BEQ   = 6'h18,
        OP_JMP   = 6'h19,
        OP_ADDIU = 6'h21,
        OP_ORIU  = 6'h24
    } opcode_e;

    function automatic logic isIllegal(input logic [OPC_W-1:0] opc);
        return (opc >= ILLEGAL_BASE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/skid_buf.sv
// ============================================================================
// Module   : skid_buf
// Brief    : Two-entry skid buffer, valid/ready on both sides, registered ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module skid_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_nextState;
    logic              r_inReady;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_skid;
    logic              w_push;
    logic              w_pop;

    assign w_push = in_valid & r_inReady;
    assign w_pop  = out_valid & out_ready;

    // Ready is derived from the next state so it never depends on out_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_EMPTY;
            r_inReady <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_inReady <= (w_nextState != S_FULL);
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (flush) begin
            w_nextState = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_push) w_nextState = S_ONE;
                S_ONE: begin
                    if (w_push && !w_pop)      w_nextState = S_FULL;
                    else if (w_pop && !w_push) w_nextState = S_EMPTY;
                end
                S_FULL:  if (w_pop) w_nextState = S_ONE;
                default: w_nextState = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (r_state != S_EMPTY);
        in_ready  = r_inReady;
        out_data  = r_head;
    end

    // Head keeps its last value whenever nothing new replaces it (including flush).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_skid <= '0;
        end else if (!flush) begin
            case (r_state)
                S_EMPTY: if (w_push) r_head <= in_data;
                S_ONE: begin
                    if (w_push && w_pop) r_head <= in_data;
                    else if (w_push)     r_skid <= in_data;
                end
                S_FULL:  if (w_pop) r_head <= r_skid;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// Module   : decode_stage
// Brief    : Buffered instruction decode with retired counter.
//            Optional illegal-opcode flag enabled by DECODE_ILLEGAL_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module decode_stage
    import decode_pkg::*;
#(
    parameter int IMM_W = 18,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       opcode,
    output logic [3:0]       rd,
    output logic [3:0]       rs,
    output logic [IMM_W-1:0] imm,
    output logic             u,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

`ifdef DECODE_ILLEGAL_CHECK_EN
    localparam int ENTRY_W = INSTR_W + 1;
`else
    localparam int ENTRY_W = INSTR_W;
`endif

    logic [ENTRY_W-1:0] w_entryIn;
    logic [ENTRY_W-1:0] w_entryOut;
    logic [INSTR_W-1:0] w_word;
    logic               w_outValid;
    logic [CNT_W-1:0]   r_retired;

    // The illegal flag travels with its instruction rather than being decoded at the output.
`ifdef DECODE_ILLEGAL_CHECK_EN
    assign w_entryIn = {isIllegal(instr_in[OPC_MSB:OPC_LSB]), instr_in};
    assign illegal   = w_entryOut[INSTR_W];
`else
    assign w_entryIn = instr_in;
    assign illegal   = 1'b0;
`endif

    skid_buf #(
        .DATA_W (ENTRY_W)
    ) u_skidBuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_entryIn),
        .out_valid (w_outValid),
        .out_ready (out_ready),
        .out_data  (w_entryOut)
    );

    assign w_word    = w_entryOut[INSTR_W-1:0];
    assign out_valid = w_outValid;
    assign opcode    = w_word[OPC_MSB:OPC_LSB];
    assign rd        = w_word[RD_MSB:RD_LSB];
    assign rs        = w_word[RS_MSB:RS_LSB];
    assign imm       = IMM_W'(w_word[IMM_MSB:IMM_LSB]);
    assign u         = w_word[OPC_MSB];

    // Counts every output handshake, including one coinciding with flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (w_outValid && out_ready) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign retired = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Randomized and directed bench for decode_stage against a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_decode_stage;

    localparam int CNT_W = 4;
    localparam int IMM_W = 18;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [31:0]      instr_in = '0;
    logic             in_ready;
    logic             out_valid;
    logic [5:0]       opcode;
    logic [3:0]       rd;
    logic [3:0]       rs;
    logic [IMM_W-1:0] imm;
    logic             u;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    decode_stage #(
        .IMM_W (IMM_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr_in  (instr_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opcode    (opcode),
        .rd        (rd),
        .rs        (rs),
        .imm       (imm),
        .u         (u),
        .illegal   (illegal),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;

    // Reference model: FIFO of accepted words, last word shown, handshake count.
    logic [31:0] mq[$];
    logic [31:0] mShown;
    int          mRetired;
    logic        mInReady;
    logic        mPushed;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic expIllegal(input logic [31:0] w);
`ifdef DECODE_ILLEGAL_CHECK_EN
        return (w[31:26] >= 6'h30);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] outWord();
        return {opcode, rd, rs, imm};
    endfunction

    task automatic modelReset();
        mq.delete();
        mShown   = '0;
        mRetired = 0;
        mInReady = 1'b0;
        mPushed  = 1'b0;
    endtask

    task automatic checkAll();
        logic [31:0] h;
        h = (mq.size() > 0) ? mq[0] : mShown;
        checkVal("in_ready",  in_ready,  mInReady);
        checkVal("out_valid", out_valid, (mq.size() > 0));
        checkVal("opcode",    opcode,    h[31:26]);
        checkVal("rd",        rd,        h[25:22]);
        checkVal("rs",        rs,        h[21:18]);
        checkVal("imm",       imm,       h[17:0]);
        checkVal("u",         u,         h[31]);
        checkVal("illegal",   illegal,   expIllegal(h));
        checkVal("retired",   retired,   mRetired % (1 << CNT_W));
    endtask

    task automatic tick();
        logic        push;
        logic        pop;
        logic [31:0] data;
        pop  = (mq.size() > 0) && out_ready;
        push = mInReady && in_valid;
        data = instr_in;
        @(posedge clk);
        if (pop) mRetired++;
        if (flush) begin
            mq.delete();
        end else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(data);
        end
        mPushed  = push && !flush;
        mInReady = (mq.size() < 2);
        if (mq.size() > 0) mShown = mq[0];
        #1;
        checkAll();
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
        in_valid  = v;
        instr_in  = w;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        int savedRet;
        int guard;
        modelReset();
        #1 rst_n = 1'b0;
        #11;
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkVal("ready_low_before_edge", in_ready, 1'b0);
        tick();

        // Basic decode and one-cycle latency
        drive(1'b1, 32'h14DE0004, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        checkVal("d1_valid",  out_valid, 1'b1);
        checkVal("d1_opcode", opcode, 6'h05);
        checkVal("d1_rd",     rd, 4'd3);
        checkVal("d1_rs",     rs, 4'd7);
        checkVal("d1_imm",    imm, 18'h20004);
        checkVal("d1_u",      u, 1'b0);
        tick();
        checkVal("d1_retired", retired, 4'd1);

        drive(1'b1, 32'h84000001, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        checkVal("d2_opcode", opcode, 6'h21);
        checkVal("d2_u",      u, 1'b1);
        checkVal("d2_imm",    imm, 18'h00001);
        tick();

        // Back-pressure: A and B fill the buffer, C is held, then drained in order
        drive(1'b1, 32'h0AAAAAAA, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0BBBBBBB, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0CCCCCCC, 1'b0, 1'b0);
        checkVal("bp_full_ready", in_ready, 1'b0);
        tick();
        tick();
        checkVal("bp_c_held", mPushed, 1'b0);
        out_ready = 1'b1;
        checkVal("bp_head_a", outWord(), 32'h0AAAAAAA);
        tick();
        checkVal("bp_head_b", outWord(), 32'h0BBBBBBB);
        tick();
        in_valid = 1'b0;
        checkVal("bp_head_c", outWord(), 32'h0CCCCCCC);
        tick();
        checkVal("bp_drained", out_valid, 1'b0);

        // Flush in FULL with a simultaneous input
        drive(1'b1, 32'h11111111, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h22222222, 1'b0, 1'b0);
        tick();
        savedRet = mRetired;
        drive(1'b1, 32'h33333333, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checkVal("fl_valid",   out_valid, 1'b0);
        checkVal("fl_retired", retired, savedRet % (1 << CNT_W));
        tick();

        // Reserved opcode
        drive(1'b1, 32'hC0000000, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
`ifdef DECODE_ILLEGAL_CHECK_EN
        checkVal("ill_flag", illegal, 1'b1);
`else
        checkVal("ill_flag", illegal, 1'b0);
`endif
        checkVal("ill_propagates", outWord(), 32'hC0000000);
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 3) == 0) w[31:28] = 4'hC | 4'($urandom_range(0, 3));
            drive(($urandom_range(0, 3) != 0), w, ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 19) == 0));
            tick();
        end

        // Asynchronous reset mid-stream
        drive(1'b1, 32'h5A5A5A5A, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        checkVal("ar_valid",  out_valid, 1'b0);
        checkVal("ar_word",   outWord(), 32'h0);
        checkVal("ar_ready",  in_ready, 1'b0);
        checkVal("ar_retired", retired, 4'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Seventeen transfers wrap a 4-bit counter to 1
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 32'h01000000 + i, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        guard = 0;
        while (mq.size() > 0 && guard < 8) begin
            tick();
            guard++;
        end
        checkVal("wrap_drained", out_valid, 1'b0);
        checkVal("wrap_retired", retired, 4'd1);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter IMM_W, default 18, immediate field width forwarded to the immediate-extension stage.
REQ-002 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous discard of all buffered instructions.
REQ-006 in_valid  input  1  upstream fetch presents instr_in.
REQ-007 in_ready  output  1  stage can accept an instruction this cycle.
REQ-008 instr_in  input  32  raw instruction word.
REQ-009 out_valid  output  1  decoded fields valid.
REQ-010 out_ready  input  1  downstream (immediate extension / execute) accepts.
REQ-011 opcode  output  6  instr[31:26].
REQ-012 rd  output  4  instr[25:22].
REQ-013 rs  output  4  instr[21:18].
REQ-014 imm  output  IMM_W  instr[17:0], unextended.
REQ-015 u  output  1  unsigned-extend select for the extension stage, equal to opcode[5].
REQ-016 illegal  output  1  decoded opcode is outside the legal set.
REQ-017 retired  output  CNT_W  count of completed output handshakes.

Function
REQ-018 Input transfer occurs when in_valid and in_ready are both 1; output transfer occurs when out_valid and out_ready are both 1.
REQ-019 Buffering is a 2-entry skid buffer with states EMPTY, ONE and FULL.
REQ-020 in_ready is 1 in EMPTY and ONE and 0 in FULL; it is a registered signal with no combinational path from out_ready.
REQ-021 Latency is one cycle: an instruction accepted at edge N appears on the outputs after edge N with out_valid=1.
REQ-022 Throughput is one instruction per cycle while out_ready=1.
REQ-023 Transitions: EMPTY->ONE on input only; ONE->FULL on input without output; ONE->EMPTY on output without input; ONE stays ONE on simultaneous input and output; FULL->ONE on output.
REQ-024 In FULL, the older entry drives the outputs and the skid entry advances to the output on the next output transfer.
REQ-025 Outputs hold stable while out_valid=1 and out_ready=0.
REQ-026 Instruction order is preserved; no instruction is dropped or duplicated.
REQ-027 Decoded fields are pure slices of the stored word, registered with the entry, and are not recomputed from instr_in.
REQ-028 retired increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
REQ-029 flush returns the state to EMPTY at the next edge, overriding a simultaneous input, and leaves retired unchanged.
REQ-030 A flush coincident with an output transfer still counts that transfer in retired.
REQ-031 With out_valid=0, the field outputs are don't-care but are held at their last values.

Reset
REQ-032 While rst_n=0: state is EMPTY, out_valid=0, in_ready=0, retired=0, all field outputs and illegal are 0.
REQ-033 in_ready rises at the first clk edge after rst_n deasserts.
REQ-034 Reset asserted mid-transfer discards both entries with no partial output.

Configuration
REQ-035 Macro DECODE_ILLEGAL_CHECK_EN selects the illegal-opcode check.
REQ-036 With DECODE_ILLEGAL_CHECK_EN defined: illegal=1 for opcode 6'h30 to 6'h3F, registered with the entry; the instruction still propagates.
REQ-037 With DECODE_ILLEGAL_CHECK_EN undefined: illegal is tied to 0 and no compare logic is present.

Structure
REQ-038 Shared package decode_pkg holds the field bit positions, the opcode width and an opcode enumeration.
REQ-039 decode_pkg also holds the ILLEGAL_BASE constant, 6'h30.
REQ-040 One sub-module skid_buf (parameterised data width, valid/ready both sides) is instantiated once.
REQ-041 Field slicing and the counter live in decode_stage itself.

Verification
REQ-042 Reset, then instr_in=32'h14DE0004 with in_valid=1 for one cycle and out_ready=1 -> next cycle: out_valid=1, opcode=6'h05, rd=3, rs=7, imm=18'h20004, u=0, retired=1 after the handshake.
REQ-043 instr_in=32'h84000001 (opcode 6'h21) -> u=1, imm=18'h00001.
REQ-044 out_ready=0 with three back-to-back inputs A, B, C -> A and B are accepted, in_ready=0 in FULL, C is held; then out_ready=1 -> outputs A, B, C in order, one per cycle.
REQ-045 flush asserted in FULL together with in_valid=1 -> next cycle: state EMPTY, out_valid=0, retired unchanged.
REQ-046 With DECODE_ILLEGAL_CHECK_EN defined, instr_in=32'hC0000000 -> illegal=1; without the macro, the same input -> illegal=0.
REQ-047 CNT_W=4 with 17 transfers -> retired=1; rst_n pulsed low mid-stream -> all outputs 0 immediately (asynchronous).
